// File: rtl/spi_write_decoder_if.sv
// Bus bundle between spi_write_decoder and its neighbours: SPI byte stream in,
// status byte out, and the valid/ready register write port.
interface spi_write_decoder_if #(
    parameter int DATA_W = 16
);
    logic [7:0]        rx_byte;
    logic              rx_valid;
    logic [7:0]        status_byte;
    logic              frame_active;
    logic              wr_valid;
    logic              wr_ready;
    logic [6:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport slave (
        input  rx_byte, rx_valid, wr_ready,
        output status_byte, frame_active, wr_valid, wr_addr, wr_data
    );

    modport master (
        output rx_byte, rx_valid, wr_ready,
        input  status_byte, frame_active, wr_valid, wr_addr, wr_data
    );
endinterface

// File: rtl/spi_write_decoder.sv
// Decodes framed SPI register-write commands {op,addr} + N data words into a
// valid/ready write port, and publishes a per-frame status byte for the slave.
//
// state | meaning
// IDLE  | waiting for a frame start (CS falling edge, armed)
// CMD   | expecting the command byte
// DATA  | shifting in data words, issuing writes
// DROP  | rejected command, ignore bytes until CS rises
module spi_write_decoder #(
    parameter int DATA_BYTES = 2,
    parameter bit AUTO_INC   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    spi_write_decoder_if.slave bus
);
    localparam int DATA_W = 8 * DATA_BYTES;
    localparam int CNT_W  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(DATA_BYTES - 1);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DROP} state_t;

    state_t state_q, state_d;

    logic              cs_m, cs_s, cs_prev;
    logic [1:0]        sync_ok;
    logic              armed;
    logic              frame_start, frame_end, byte_in;

    logic [CNT_W-1:0]  byte_cnt;
    logic [6:0]        addr;
    logic [DATA_W-1:0] word;
    logic [DATA_W+7:0] word_wide;
    logic [DATA_W-1:0] word_next;
    logic              overrun, short_f, bad_cmd;
    logic [3:0]        frame_cnt;

    logic              clr_flags, set_bad, set_short, frame_done;
    logic              cmd_take, data_take, word_done, can_load, accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_m    <= 1'b1;
            cs_s    <= 1'b1;
            cs_prev <= 1'b1;
            sync_ok <= 2'b00;
            armed   <= 1'b0;
        end else begin
            cs_m    <= cs;
            cs_s    <= cs_m;
            cs_prev <= cs_s;
            sync_ok <= {sync_ok[0], 1'b1};
            // cs_s holds its reset value for two cycles; only arm once it reflects the real pin
            if (cs_s && sync_ok[1])
                armed <= 1'b1;
        end
    end

    assign frame_start = armed & ~cs_s & cs_prev;
    assign frame_end   = cs_s & ~cs_prev;
    assign byte_in     = bus.rx_valid & ~cs_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        clr_flags  = 1'b0;
        set_bad    = 1'b0;
        set_short  = 1'b0;
        frame_done = 1'b0;
        cmd_take   = 1'b0;
        data_take  = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d   = CMD;
                    clr_flags = 1'b1;
                end
            end
            CMD: begin
                if (frame_end) begin
                    state_d    = IDLE;
                    frame_done = 1'b1;
                end else if (byte_in) begin
                    if (bus.rx_byte[7]) begin
                        state_d = DROP;
                        set_bad = 1'b1;
                    end else begin
                        state_d  = DATA;
                        cmd_take = 1'b1;
                    end
                end
            end
            DATA: begin
                if (frame_end) begin
                    state_d    = IDLE;
                    frame_done = 1'b1;
                    set_short  = (byte_cnt != '0);
                end else if (byte_in) begin
                    data_take = 1'b1;
                end
            end
            DROP: begin
                if (frame_end) begin
                    state_d    = IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign word_wide = {word, bus.rx_byte};
    assign word_next = word_wide[DATA_W-1:0];
    assign word_done = data_take & (byte_cnt == LAST_BYTE);
    assign can_load  = ~bus.wr_valid | bus.wr_ready;
    assign accept    = bus.wr_valid & bus.wr_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt        <= '0;
            addr            <= '0;
            word            <= '0;
            overrun         <= 1'b0;
            short_f         <= 1'b0;
            bad_cmd         <= 1'b0;
            frame_cnt       <= '0;
            bus.wr_valid    <= 1'b0;
            bus.wr_addr     <= '0;
            bus.wr_data     <= '0;
            bus.status_byte <= '0;
        end else begin
            if (clr_flags)
                byte_cnt <= '0;
            if (cmd_take)
                addr <= bus.rx_byte[6:0];
            if (data_take) begin
                word <= word_next;
                if (word_done) begin
                    byte_cnt <= '0;
                    addr     <= addr + {6'd0, AUTO_INC};
                end else begin
                    byte_cnt <= byte_cnt + CNT_W'(1);
                end
            end

            if (word_done && can_load) begin
                bus.wr_valid <= 1'b1;
                bus.wr_addr  <= addr;
                bus.wr_data  <= word_next;
            end else if (accept) begin
                bus.wr_valid <= 1'b0;
            end

            // set terms come last so a same-cycle set beats the frame-start clear
            overrun   <= (overrun & ~clr_flags) | (word_done & ~can_load);
            short_f   <= (short_f & ~clr_flags) | set_short;
            bad_cmd   <= (bad_cmd & ~clr_flags) | set_bad;
            frame_cnt <= frame_cnt + {3'd0, frame_done};

            bus.status_byte <= {bus.wr_valid, overrun, short_f, bad_cmd, frame_cnt};
        end
    end

    assign bus.frame_active = (state_q != IDLE);

endmodule
